// File: rtl/connect4_pkg.sv
// ---------------------------------------------------------------------------
// connect4_pkg
//   Shared types and default dimensions for the Connect-Four board logic.
//   - DEF_ROWS / DEF_COLS / DEF_COL_W : default board geometry
//   - cell_t       : contents of one board cell (2 bits)
//   - drop_state_t : states of the drop controller
//   - cell_idx()   : bit offset of cell (row, col) in the flattened board
// ---------------------------------------------------------------------------
package connect4_pkg;

   localparam int DEF_ROWS  = 6;
   localparam int DEF_COLS  = 7;
   localparam int DEF_COL_W = 3;

   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      RED    = 2'b01,
      YELLOW = 2'b10
   } cell_t;

   typedef enum logic [1:0] {
      IDLE,
      FALL,
      PLACE
   } drop_state_t;

   // Row 0 is the top row; cells are laid out row-major, two bits each.
   function automatic int cell_idx(input int row, input int col, input int cols);
      return 2 * (row * cols + col);
   endfunction

endpackage

// File: rtl/colocador_ficha_if.sv
// ---------------------------------------------------------------------------
// colocador_ficha_if
//   Bundle between the column-select logic / turn tracker (master) and the
//   drop controller (slave).
//   master -> slave : enable, new_game, col_sel, drop_req, is_red, fall_tick
//   slave -> master : busy, fall_active, fall_row, fall_col, ficha_colocada,
//                     invalid_move, last_row, last_col, board, board_full
// ---------------------------------------------------------------------------
interface colocador_ficha_if #(
   parameter int ROWS  = connect4_pkg::DEF_ROWS,
   parameter int COLS  = connect4_pkg::DEF_COLS,
   parameter int COL_W = connect4_pkg::DEF_COL_W
) ();

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   // Requests and game control
   logic                   enable;
   logic                   new_game;
   logic [COL_W-1:0]       col_sel;
   logic                   drop_req;
   logic                   is_red;
   logic                   fall_tick;

   // Drop status, animation and board view
   logic                   busy;
   logic                   fall_active;
   logic [ROW_W-1:0]       fall_row;
   logic [COL_W-1:0]       fall_col;
   logic                   ficha_colocada;
   logic                   invalid_move;
   logic [ROW_W-1:0]       last_row;
   logic [COL_W-1:0]       last_col;
   logic [ROWS*COLS*2-1:0] board;
   logic                   board_full;

   modport master (
      output enable, new_game, col_sel, drop_req, is_red, fall_tick,
      input  busy, fall_active, fall_row, fall_col, ficha_colocada,
             invalid_move, last_row, last_col, board, board_full
   );

   modport slave (
      input  enable, new_game, col_sel, drop_req, is_red, fall_tick,
      output busy, fall_active, fall_row, fall_col, ficha_colocada,
             invalid_move, last_row, last_col, board, board_full
   );

endinterface

// File: rtl/alturas_columnas.sv
// ---------------------------------------------------------------------------
// alturas_columnas
//   Per-column fill counters for the board.
//   clk, reset    : clock, async active-high reset (all heights 0)
//   clr_i         : synchronous clear of every height (has priority)
//   inc_i         : add one piece to column inc_col_i
//   inc_col_i     : column being incremented
//   sel_col_i     : column being queried
//   sel_height_o  : height of sel_col_i (0 when out of range)
//   col_full_o    : per-column "height == ROWS" flags
//   board_full_o  : registered, every column full; moves with the heights
// ---------------------------------------------------------------------------
module alturas_columnas #(
   parameter int ROWS  = connect4_pkg::DEF_ROWS,
   parameter int COLS  = connect4_pkg::DEF_COLS,
   parameter int COL_W = connect4_pkg::DEF_COL_W,
   parameter int HGT_W = $clog2(ROWS + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [COL_W-1:0] inc_col_i,
   input  logic [COL_W-1:0] sel_col_i,
   output logic [HGT_W-1:0] sel_height_o,
   output logic [COLS-1:0]  col_full_o,
   output logic             board_full_o
);

   logic [HGT_W-1:0] heights_q [COLS];
   logic [HGT_W-1:0] heights_d [COLS];
   logic             board_full_q;
   logic             board_full_d;

   always_comb begin
      // NOTE: every output of this block gets a value before any branch, so
      // no path leaves a signal unassigned and no latch is inferred.
      board_full_d = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         heights_d[c] = heights_q[c];
         if (clr_i)
            heights_d[c] = '0;
         else if (inc_i && (int'(inc_col_i) == c) && (heights_q[c] != HGT_W'(ROWS)))
            heights_d[c] = heights_q[c] + HGT_W'(1);
         if (heights_d[c] != HGT_W'(ROWS))
            board_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < COLS; c++)
            heights_q[c] <= '0;
         board_full_q <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every
         // register samples the values from before this edge.
         for (int c = 0; c < COLS; c++)
            heights_q[c] <= heights_d[c];
         board_full_q <= board_full_d;
      end
   end

   // Column lookup by comparison: an out-of-range select simply reads 0.
   always_comb begin
      sel_height_o = '0;
      for (int c = 0; c < COLS; c++) begin
         col_full_o[c] = (heights_q[c] == HGT_W'(ROWS));
         if (int'(sel_col_i) == c)
            sel_height_o = heights_q[c];
      end
   end

   assign board_full_o = board_full_q;

endmodule

// File: rtl/colocador_ficha.sv
// ---------------------------------------------------------------------------
// colocador_ficha
//   Connect-Four drop controller. Validates a column request, animates the
//   piece falling one row per fall_tick, writes it into the board and pulses
//   ficha_colocada. Full or out-of-range columns pulse invalid_move instead.
//   clk, reset : clock, async active-high reset
//   bus        : colocador_ficha_if.slave
//                in : enable, new_game, col_sel, drop_req, is_red, fall_tick
//                out: busy, fall_active, fall_row, fall_col, ficha_colocada,
//                     invalid_move, last_row, last_col, board, board_full
// ---------------------------------------------------------------------------
module colocador_ficha #(
   parameter int ROWS  = connect4_pkg::DEF_ROWS,
   parameter int COLS  = connect4_pkg::DEF_COLS,
   parameter int COL_W = connect4_pkg::DEF_COL_W
) (
   input  logic             clk,
   input  logic             reset,
   colocador_ficha_if.slave bus
);

   import connect4_pkg::*;

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int HGT_W = $clog2(ROWS + 1);

   drop_state_t            state_q;
   cell_t                  colour_q;
   logic [ROW_W-1:0]       fall_row_q;
   logic [ROW_W-1:0]       target_q;
   logic [COL_W-1:0]       fall_col_q;
   logic [ROW_W-1:0]       last_row_q;
   logic [COL_W-1:0]       last_col_q;
   logic                   busy_q;
   logic                   fall_active_q;
   logic                   ficha_q;
   logic                   invalid_q;
   logic [ROWS*COLS*2-1:0] board_q;

   logic [HGT_W-1:0]       sel_height;
   logic [COLS-1:0]        col_full;
   logic                   board_full;
   logic                   col_in_range;
   logic                   sel_full;
   logic                   accept;
   logic                   reject;
   logic                   place_now;
   logic [ROW_W-1:0]       target_d;

   // Heights only move on the PLACE edge, so the query for col_sel is stable
   // whenever a request is evaluated in IDLE.
   alturas_columnas #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .COL_W (COL_W),
      .HGT_W (HGT_W)
   ) u_alturas (
      .clk          (clk),
      .reset        (reset),
      .clr_i        (bus.new_game),
      .inc_i        (place_now),
      .inc_col_i    (fall_col_q),
      .sel_col_i    (bus.col_sel),
      .sel_height_o (sel_height),
      .col_full_o   (col_full),
      .board_full_o (board_full)
   );

   // Request classification; only acted upon while IDLE.
   always_comb begin
      col_in_range = (int'(bus.col_sel) < COLS);
      sel_full     = 1'b0;
      for (int c = 0; c < COLS; c++)
         if (int'(bus.col_sel) == c)
            sel_full = col_full[c];
      accept   = bus.enable && bus.drop_req && col_in_range && !sel_full;
      reject   = bus.enable && bus.drop_req && !(col_in_range && !sel_full);
      // Landing row: pieces stack upward from row ROWS-1.
      target_d = ROW_W'(ROWS - 1 - int'(sel_height));
   end

   // A new_game on the PLACE edge aborts the drop, so no height is counted.
   assign place_now = (state_q == PLACE) && !bus.new_game;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         colour_q      <= EMPTY;
         fall_row_q    <= '0;
         target_q      <= '0;
         fall_col_q    <= '0;
         last_row_q    <= '0;
         last_col_q    <= '0;
         busy_q        <= 1'b0;
         fall_active_q <= 1'b0;
         ficha_q       <= 1'b0;
         invalid_q     <= 1'b0;
         // NOTE: the board is game state that must read EMPTY after reset,
         // so it is built from resettable flops rather than a RAM.
         board_q       <= '0;
      end else begin
         ficha_q   <= 1'b0;
         invalid_q <= 1'b0;
         if (bus.new_game) begin
            state_q       <= IDLE;
            fall_row_q    <= '0;
            fall_col_q    <= '0;
            last_row_q    <= '0;
            last_col_q    <= '0;
            busy_q        <= 1'b0;
            fall_active_q <= 1'b0;
            board_q       <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (accept) begin
                     colour_q      <= bus.is_red ? RED : YELLOW;
                     fall_col_q    <= bus.col_sel;
                     fall_row_q    <= '0;
                     target_q      <= target_d;
                     busy_q        <= 1'b1;
                     fall_active_q <= 1'b1;
                     state_q       <= FALL;
                  end else if (reject) begin
                     invalid_q <= 1'b1;
                  end
               end
               FALL: begin
                  // Reaching the target ends the animation without a tick.
                  if (fall_row_q == target_q) begin
                     fall_active_q <= 1'b0;
                     state_q       <= PLACE;
                  end else if (bus.fall_tick) begin
                     fall_row_q <= fall_row_q + ROW_W'(1);
                  end
               end
               PLACE: begin
                  board_q[cell_idx(int'(target_q), int'(fall_col_q), COLS) +: 2] <= colour_q;
                  last_row_q <= target_q;
                  last_col_q <= fall_col_q;
                  ficha_q    <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end
               default: begin
                  state_q       <= IDLE;
                  busy_q        <= 1'b0;
                  fall_active_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.busy           = busy_q;
   assign bus.fall_active    = fall_active_q;
   assign bus.fall_row       = fall_row_q;
   assign bus.fall_col       = fall_col_q;
   assign bus.ficha_colocada = ficha_q;
   assign bus.invalid_move   = invalid_q;
   assign bus.last_row       = last_row_q;
   assign bus.last_col       = last_col_q;
   assign bus.board          = board_q;
   assign bus.board_full     = board_full;

endmodule

// File: tb/tb_colocador_ficha.sv
// ---------------------------------------------------------------------------
// tb_colocador_ficha
//   Self-checking bench for colocador_ficha: directed sequences, a table of
//   drop vectors and randomized drops against a board-level reference model.
// ---------------------------------------------------------------------------
module tb_colocador_ficha;

   import connect4_pkg::*;

   localparam int ROWS  = 6;
   localparam int COLS  = 7;
   localparam int COL_W = 3;
   localparam int NB    = ROWS * COLS * 2;

   localparam int OUT_TIMEOUT = 0;
   localparam int OUT_PLACED  = 1;
   localparam int OUT_INVALID = 2;
   localparam int OUT_IGNORED = 3;

   typedef struct {
      int col;
      bit red;
      int exp_out;
      int exp_row;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   bit   tick_rand = 1'b0;
   bit   spur_en   = 1'b0;
   int   n_checks  = 0;
   int   n_fail    = 0;

   // Reference board: 0 empty, 1 red, 2 yellow; row 0 on top.
   int   mcell [ROWS][COLS];

   colocador_ficha_if #(.ROWS(ROWS), .COLS(COLS), .COL_W(COL_W)) bus ();

   colocador_ficha #(.ROWS(ROWS), .COLS(COLS), .COL_W(COL_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Animation strobe: every cycle, or random when tick_rand is set.
   initial begin
      bus.fall_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.fall_tick = tick_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NB-1:0] model_pack();
      logic [NB-1:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            v[2*(r*COLS+c) +: 2] = 2'(mcell[r][c]);
      return v;
   endfunction

   function automatic int mheight(input int c);
      int h;
      h = 0;
      for (int r = 0; r < ROWS; r++)
         if (mcell[r][c] != 0) h++;
      return h;
   endfunction

   function automatic bit model_full();
      for (int c = 0; c < COLS; c++)
         if (mheight(c) != ROWS) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            mcell[r][c] = 0;
   endtask

   task automatic do_new_game();
      bus.new_game = 1'b1;
      tick();
      bus.new_game = 1'b0;
      model_clear();
   endtask

   // Issues one request and follows it to placement, rejection or silence.
   task automatic apply_drop(input string tag, input int col, input bit red,
                             input int exp_out, input int exp_row);
      int    outcome;
      int    lat;
      bit    clash;
      cell_t colour;
      colour  = red ? RED : YELLOW;
      outcome = OUT_TIMEOUT;
      lat     = -1;
      clash   = 1'b0;
      bus.col_sel  = COL_W'(col);
      bus.is_red   = red;
      bus.drop_req = 1'b1;
      tick();
      bus.drop_req = 1'b0;
      if (bus.invalid_move) begin
         outcome = OUT_INVALID;
         lat     = 0;
      end else if (!bus.busy) begin
         outcome = OUT_IGNORED;
         lat     = 0;
      end else begin
         for (int k = 1; k <= 200; k++) begin
            bus.is_red = ~bus.is_red;
            if (spur_en && ($urandom_range(0, 3) == 0)) begin
               bus.col_sel  = COL_W'($urandom_range(0, 7));
               bus.drop_req = 1'b1;
            end
            tick();
            bus.drop_req = 1'b0;
            if (bus.ficha_colocada && bus.invalid_move) clash = 1'b1;
            if (bus.ficha_colocada) begin
               outcome = OUT_PLACED;
               lat     = k;
               break;
            end
         end
      end
      check({tag, " outcome"}, outcome, exp_out);
      check({tag, " pulse clash"}, clash, 1'b0);
      if (exp_out == OUT_PLACED) begin
         mcell[exp_row][col] = int'(colour);
         if (!tick_rand) check({tag, " latency"}, lat, exp_row + 2);
         check({tag, " last_row"}, bus.last_row, exp_row);
         check({tag, " last_col"}, bus.last_col, col);
         check({tag, " busy after place"}, bus.busy, 1'b0);
         check({tag, " fall_active after place"}, bus.fall_active, 1'b0);
      end
      check({tag, " board"}, bus.board, model_pack());
      check({tag, " board_full"}, bus.board_full, model_full());
      tick();
      check({tag, " pulse width"}, {bus.ficha_colocada, bus.invalid_move}, 2'b00);
   endtask

   initial begin
      vec_t vecs[$];
      vec_t v;
      int   pulses;
      int   invs;

      model_clear();
      bus.enable   = 1'b0;
      bus.new_game = 1'b0;
      bus.col_sel  = '0;
      bus.drop_req = 1'b0;
      bus.is_red   = 1'b0;
      reset        = 1'b1;

      // ---- Reset state ----
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", bus.busy, 1'b0);
      check("rst fall_active", bus.fall_active, 1'b0);
      check("rst pulses", {bus.ficha_colocada, bus.invalid_move}, 2'b00);
      check("rst board_full", bus.board_full, 1'b0);
      check("rst fall pos", {bus.fall_row, bus.fall_col}, '0);
      check("rst last pos", {bus.last_row, bus.last_col}, '0);
      check("rst board", bus.board, '0);
      reset = 1'b0;
      tick();

      // ---- First drop: red into column 3, full fall with a tick each cycle ----
      bus.enable   = 1'b1;
      bus.col_sel  = 3'd3;
      bus.is_red   = 1'b1;
      bus.drop_req = 1'b1;
      tick();
      bus.drop_req = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         check($sformatf("t1 fall_row step %0d", k), bus.fall_row, k);
         check($sformatf("t1 fall_active step %0d", k), bus.fall_active, 1'b1);
         check($sformatf("t1 busy step %0d", k), bus.busy, 1'b1);
         if (k < 5) tick();
      end
      check("t1 fall_col", bus.fall_col, 3);
      tick();
      check("t1 place state", {bus.busy, bus.fall_active, bus.ficha_colocada}, 3'b100);
      tick();
      check("t1 ficha_colocada", bus.ficha_colocada, 1'b1);
      mcell[5][3] = int'(RED);
      check("t1 board", bus.board, model_pack());
      check("t1 last pos", {bus.last_row, bus.last_col}, {3'd5, 3'd3});
      check("t1 busy", bus.busy, 1'b0);
      tick();
      check("t1 pulse width", bus.ficha_colocada, 1'b0);

      // ---- Table: fill column 0, overflow, out-of-range, edge column ----
      for (int i = 0; i < ROWS; i++) begin
         v.col = 0; v.red = (i % 2 == 0); v.exp_out = OUT_PLACED; v.exp_row = 5 - i;
         vecs.push_back(v);
      end
      v.col = 0; v.red = 1'b1; v.exp_out = OUT_INVALID; v.exp_row = 0; vecs.push_back(v);
      v.col = 7; v.red = 1'b0; v.exp_out = OUT_INVALID; v.exp_row = 0; vecs.push_back(v);
      v.col = 6; v.red = 1'b1; v.exp_out = OUT_PLACED;  v.exp_row = 5; vecs.push_back(v);
      v.col = 3; v.red = 1'b0; v.exp_out = OUT_PLACED;  v.exp_row = 4; vecs.push_back(v);
      foreach (vecs[i])
         apply_drop($sformatf("vec%0d", i), vecs[i].col, vecs[i].red,
                    vecs[i].exp_out, vecs[i].exp_row);

      // ---- Request during FALL is ignored ----
      do_new_game();
      check("ng board clear", bus.board, '0);
      bus.col_sel  = 3'd4;
      bus.is_red   = 1'b0;
      bus.drop_req = 1'b1;
      tick();
      bus.drop_req = 1'b0;
      check("ign accept busy", bus.busy, 1'b1);
      tick();
      bus.col_sel  = 3'd2;
      bus.is_red   = 1'b1;
      bus.drop_req = 1'b1;
      tick();
      bus.drop_req = 1'b0;
      check("ign no invalid", bus.invalid_move, 1'b0);
      pulses = 0;
      invs   = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         pulses += int'(bus.ficha_colocada);
         invs   += int'(bus.invalid_move);
      end
      check("ign pulse count", pulses, 1);
      check("ign invalid count", invs, 0);
      mcell[5][4] = int'(YELLOW);
      check("ign board", bus.board, model_pack());

      // ---- new_game in the middle of a fall ----
      bus.col_sel  = 3'd1;
      bus.is_red   = 1'b1;
      bus.drop_req = 1'b1;
      tick();
      bus.drop_req = 1'b0;
      tick();
      tick();
      check("ngf fall_row", bus.fall_row, 2);
      do_new_game();
      check("ngf busy", {bus.busy, bus.fall_active}, 2'b00);
      check("ngf board", bus.board, '0);
      check("ngf last pos", {bus.last_row, bus.last_col}, '0);
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         pulses += int'(bus.ficha_colocada);
      end
      check("ngf no pulse", pulses, 0);
      apply_drop("ngf redrop", 1, 1'b1, OUT_PLACED, 5);

      // ---- enable low: requests ignored silently ----
      bus.enable = 1'b0;
      apply_drop("dis col2", 2, 1'b0, OUT_IGNORED, 0);
      apply_drop("dis col7", 7, 1'b0, OUT_IGNORED, 0);
      bus.enable = 1'b1;

      // ---- Fill all 42 cells ----
      do_new_game();
      for (int i = 0; i < ROWS * COLS; i++)
         apply_drop($sformatf("full%0d", i), i % COLS, 1'(i % 2), OUT_PLACED, 5 - i / COLS);
      check("full flag", bus.board_full, 1'b1);
      apply_drop("full extra", 3, 1'b1, OUT_INVALID, 0);

      // ---- Randomized drops against the reference model ----
      do_new_game();
      check("rnd start board_full", bus.board_full, 1'b0);
      tick_rand = 1'b1;
      spur_en   = 1'b1;
      for (int n = 0; n < 150; n++) begin
         int col;
         bit red;
         int h;
         int exp_out;
         if (model_full() || ($urandom_range(0, 29) == 0)) begin
            do_new_game();
            check($sformatf("rnd%0d new_game board", n), bus.board, '0);
         end
         col = $urandom_range(0, 7);
         red = 1'($urandom_range(0, 1));
         h   = (col < COLS) ? mheight(col) : ROWS;
         bus.enable = ($urandom_range(0, 14) != 0);
         if (!bus.enable)
            exp_out = OUT_IGNORED;
         else if (h == ROWS)
            exp_out = OUT_INVALID;
         else
            exp_out = OUT_PLACED;
         apply_drop($sformatf("rnd%0d", n), col, red, exp_out, ROWS - 1 - h);
      end
      bus.enable = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
